// File: rtl/carp_cu_pkg.sv
// Shared encodings for the CARP multi-cycle control unit.
package carp_cu_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Instruction class: selects the EXEC/MEM/WB path taken after DECODE.
    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5
    } op_class_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Immediate formats, shared with the immediate generator.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_SEL_PC4  = 2'd0;
    localparam logic [1:0] PC_SEL_JALR = 2'd1;
    localparam logic [1:0] PC_SEL_BR   = 2'd2;
    localparam logic [1:0] PC_SEL_JAL  = 2'd3;

    localparam logic [1:0] RF_WR_ALU = 2'd0;
    localparam logic [1:0] RF_WR_MEM = 2'd1;
    localparam logic [1:0] RF_WR_PC4 = 2'd2;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic SRCB_RS2 = 1'b0;
    localparam logic SRCB_IMM = 1'b1;

endpackage

// File: rtl/cu_opcode_decode.sv
// Purely combinational opcode decoder; the sequencer registers its outputs in DECODE.
module cu_opcode_decode
    import carp_cu_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic [1:0] srca,
    output logic       srcb,
    output op_class_t  op_class,
    output logic       legal
);

    // Opcode to immediate format, ALU operand sources and instruction class.
    always_comb begin
        imm_sel  = IMM_I;
        srca     = SRCA_RS1;
        srcb     = SRCB_RS2;
        op_class = CLS_ALU;
        legal    = 1'b1;
        case (opcode)
            OPC_LUI: begin
                imm_sel = IMM_U;
                srca    = SRCA_ZERO;
                srcb    = SRCB_IMM;
            end
            OPC_AUIPC: begin
                imm_sel = IMM_U;
                srca    = SRCA_PC;
                srcb    = SRCB_IMM;
            end
            OPC_JAL: begin
                imm_sel  = IMM_J;
                op_class = CLS_JAL;
            end
            OPC_JALR: begin
                imm_sel  = IMM_I;
                op_class = CLS_JALR;
            end
            OPC_BRANCH: begin
                imm_sel  = IMM_B;
                op_class = CLS_BRANCH;
            end
            OPC_LOAD: begin
                imm_sel  = IMM_I;
                srcb     = SRCB_IMM;
                op_class = CLS_LOAD;
            end
            OPC_STORE: begin
                imm_sel  = IMM_S;
                srcb     = SRCB_IMM;
                op_class = CLS_STORE;
            end
            OPC_OPIMM: begin
                imm_sel = IMM_I;
                srcb    = SRCB_IMM;
            end
            OPC_OP: begin
                imm_sel = IMM_I;
                srcb    = SRCB_RS2;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_mc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with memory watchdog and retire counter.
module cu_mc_sequencer
    import carp_cu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      IR,
    input  logic             MEM_RDY,
    input  logic             BR_TAKEN,
    output logic             IR_WE,
    output logic             IMEM_RDEN,
    output logic             DMEM_RDEN,
    output logic             DMEM_WE,
    output logic             PC_WE,
    output logic [1:0]       PC_SEL,
    output logic             RF_WE,
    output logic [1:0]       RF_WR_SEL,
    output logic [1:0]       ALU_SRCA,
    output logic             ALU_SRCB,
    output logic [2:0]       IMM_SEL,
    output logic             ILLEGAL,
    output logic             BUS_ERR,
    output logic [CNT_W-1:0] RETIRED
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state_reg, state_next;
    logic [2:0]      imm_sel_reg;
    logic [1:0]      srca_reg;
    logic            srcb_reg;
    op_class_t       class_reg;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            wd_expired;
    logic            illegal_reg, bus_err_reg;
    logic [CNT_W-1:0] retired_reg;

    logic [2:0]      dec_imm_sel;
    logic [1:0]      dec_srca;
    logic            dec_srcb;
    op_class_t       dec_class;
    logic            dec_legal;

    // Only the opcode field steers the sequencer.
    logic unused_ir;
    assign unused_ir = ^IR[31:7];

    cu_opcode_decode u_decode (
        .opcode   (IR[6:0]),
        .imm_sel  (dec_imm_sel),
        .srca     (dec_srca),
        .srcb     (dec_srcb),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    // Watchdog fires on the TIMEOUT-th consecutive wait cycle; a same-cycle MEM_RDY wins.
    always_comb begin
        wd_expired = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !MEM_RDY
                     && (wd_reg == WD_W'(TIMEOUT - 1));
        wd_next = '0;
        if (((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !MEM_RDY
            && (state_next == state_reg)) begin
            wd_next = wd_reg + WD_W'(1);
        end
    end

    // Next-state and strobe decode from current state and registered selects.
    always_comb begin
        state_next = state_reg;
        IR_WE      = 1'b0;
        IMEM_RDEN  = 1'b0;
        DMEM_RDEN  = 1'b0;
        DMEM_WE    = 1'b0;
        PC_WE      = 1'b0;
        PC_SEL     = PC_SEL_PC4;
        RF_WE      = 1'b0;
        RF_WR_SEL  = RF_WR_ALU;
        case (state_reg)
            ST_INIT: state_next = ST_FETCH;
            ST_FETCH: begin
                IMEM_RDEN = 1'b1;
                if (MEM_RDY) begin
                    IR_WE      = 1'b1;
                    state_next = ST_DECODE;
                end else if (wd_expired) begin
                    state_next = ST_TRAP;
                end
            end
            ST_DECODE: state_next = dec_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (class_reg)
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    CLS_BRANCH: begin
                        PC_WE      = 1'b1;
                        PC_SEL     = BR_TAKEN ? PC_SEL_BR : PC_SEL_PC4;
                        state_next = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        RF_WE      = 1'b1;
                        RF_WR_SEL  = RF_WR_PC4;
                        PC_WE      = 1'b1;
                        PC_SEL     = (class_reg == CLS_JAL) ? PC_SEL_JAL : PC_SEL_JALR;
                        state_next = ST_FETCH;
                    end
                    default: begin
                        RF_WE      = 1'b1;
                        RF_WR_SEL  = RF_WR_ALU;
                        PC_WE      = 1'b1;
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (class_reg == CLS_LOAD) begin
                    DMEM_RDEN = 1'b1;
                end else begin
                    DMEM_WE = 1'b1;
                end
                if (MEM_RDY) begin
                    if (class_reg == CLS_LOAD) begin
                        state_next = ST_WB;
                    end else begin
                        PC_WE      = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (wd_expired) begin
                    state_next = ST_TRAP;
                end
            end
            ST_WB: begin
                RF_WE      = 1'b1;
                RF_WR_SEL  = RF_WR_MEM;
                PC_WE      = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_INIT;
        endcase
    end

    // State register and watchdog counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_INIT;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
        end
    end

    // Datapath selects captured in DECODE and held until the next DECODE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            imm_sel_reg <= IMM_I;
            srca_reg    <= SRCA_RS1;
            srcb_reg    <= SRCB_RS2;
            class_reg   <= CLS_ALU;
        end else if (state_reg == ST_DECODE) begin
            imm_sel_reg <= dec_imm_sel;
            srca_reg    <= dec_srca;
            srcb_reg    <= dec_srcb;
            class_reg   <= dec_class;
        end
    end

    // Sticky trap flags and retired-instruction counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            if ((state_reg == ST_DECODE) && !dec_legal) begin
                illegal_reg <= 1'b1;
            end
            if (wd_expired) begin
                bus_err_reg <= 1'b1;
            end
            if (PC_WE) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    assign IMM_SEL  = imm_sel_reg;
    assign ALU_SRCA = srca_reg;
    assign ALU_SRCB = srcb_reg;
    assign ILLEGAL  = illegal_reg;
    assign BUS_ERR  = bus_err_reg;
    assign RETIRED  = retired_reg;

endmodule

// File: tb/tb_cu_mc_sequencer.sv
// Randomized self-checking bench for cu_mc_sequencer against a per-instruction cycle model.
module tb_cu_mc_sequencer;

    localparam int TO = 16;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [31:0]   IR = 32'h0;
    logic          MEM_RDY = 1'b0;
    logic          BR_TAKEN = 1'b0;
    logic          IR_WE, IMEM_RDEN, DMEM_RDEN, DMEM_WE, PC_WE, RF_WE;
    logic [1:0]    PC_SEL, RF_WR_SEL, ALU_SRCA;
    logic          ALU_SRCB;
    logic [2:0]    IMM_SEL;
    logic          ILLEGAL, BUS_ERR;
    logic [CW-1:0] RETIRED;

    int checks = 0;
    int failures = 0;
    int retired_model = 0;

    cu_mc_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .MEM_RDY(MEM_RDY), .BR_TAKEN(BR_TAKEN),
        .IR_WE(IR_WE), .IMEM_RDEN(IMEM_RDEN), .DMEM_RDEN(DMEM_RDEN), .DMEM_WE(DMEM_WE),
        .PC_WE(PC_WE), .PC_SEL(PC_SEL), .RF_WE(RF_WE), .RF_WR_SEL(RF_WR_SEL),
        .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB), .IMM_SEL(IMM_SEL),
        .ILLEGAL(ILLEGAL), .BUS_ERR(BUS_ERR), .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    // {IR_WE, IMEM_RDEN, DMEM_RDEN, DMEM_WE, PC_WE, PC_SEL, RF_WE, RF_WR_SEL}
    logic [9:0] strobes;
    assign strobes = {IR_WE, IMEM_RDEN, DMEM_RDEN, DMEM_WE, PC_WE, PC_SEL, RF_WE, RF_WR_SEL};

    localparam logic [2:0] K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;

    typedef struct packed {
        logic       legal;
        logic [2:0] cls;
        logic [2:0] imm;
        logic [1:0] sa;
        logic       sb;
    } ref_t;

    // Instruction-set table: opcode -> class, immediate format, operand sources.
    function automatic ref_t ref_of(input logic [6:0] opc);
        ref_t r;
        r = '{legal: 1'b1, cls: K_ALU, imm: 3'd0, sa: 2'd0, sb: 1'b0};
        case (opc)
            7'b0110111: begin r.imm = 3; r.sa = 2; r.sb = 1; end
            7'b0010111: begin r.imm = 3; r.sa = 1; r.sb = 1; end
            7'b1101111: begin r.imm = 4; r.cls = K_JAL; end
            7'b1100111: begin r.imm = 0; r.cls = K_JALR; end
            7'b1100011: begin r.imm = 2; r.cls = K_BR; end
            7'b0000011: begin r.imm = 0; r.sb = 1; r.cls = K_LD; end
            7'b0100011: begin r.imm = 1; r.sb = 1; r.cls = K_ST; end
            7'b0010011: begin r.imm = 0; r.sb = 1; end
            7'b0110011: begin r.imm = 0; r.sb = 0; end
            default:    r.legal = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] sv(input logic irwe, input logic imem, input logic drd,
                                      input logic dwe, input logic pcwe, input logic [1:0] pcsel,
                                      input logic rfwe, input logic [1:0] rfsel);
        return {irwe, imem, drd, dwe, pcwe, pcsel, rfwe, rfsel};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply MEM_RDY, compare strobes mid-cycle, advance past the edge.
    task automatic cyc(input logic rdy, input logic [9:0] exp, input string tag);
        MEM_RDY = rdy;
        @(negedge CLK);
        check(tag, {22'd0, strobes}, {22'd0, exp});
        if (exp[5]) retired_model++;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_retired(input string tag);
        check(tag, {27'd0, RETIRED}, 32'(retired_model % (1 << CW)));
    endtask

    // Reset pulse (strobes must drop at once), then the single INIT cycle.
    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        MEM_RDY = 1'b0;
        @(negedge CLK);
        check({tag, " rst_strobes"}, {22'd0, strobes}, 32'd0);
        check({tag, " rst_regs"}, {24'd0, IMM_SEL, ALU_SRCA, ALU_SRCB, ILLEGAL, BUS_ERR},
              32'd0);
        check({tag, " rst_retired"}, {27'd0, RETIRED}, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        retired_model = 0;
        cyc(1'b0, 10'd0, {tag, " init"});
    endtask

    // Run one instruction from the first FETCH cycle through retirement.
    task automatic run_instr(input logic [31:0] ir, input int fw, input int mw, input logic br,
                             input string tag);
        ref_t r;
        r = ref_of(ir[6:0]);
        IR = ir;
        BR_TAKEN = br;
        for (int i = 0; i < fw; i++) cyc(1'b0, sv(0, 1, 0, 0, 0, 0, 0, 0), {tag, " fetch_wait"});
        cyc(1'b1, sv(1, 1, 0, 0, 0, 0, 0, 0), {tag, " fetch_ack"});
        cyc(1'b0, 10'd0, {tag, " decode"});
        if (!r.legal) return;
        case (r.cls)
            K_LD, K_ST: cyc(1'b0, 10'd0, {tag, " exec"});
            K_BR:       cyc(1'b0, sv(0, 0, 0, 0, 1, br ? 2'd2 : 2'd0, 0, 0), {tag, " exec"});
            K_JAL:      cyc(1'b0, sv(0, 0, 0, 0, 1, 2'd3, 1, 2'd2), {tag, " exec"});
            K_JALR:     cyc(1'b0, sv(0, 0, 0, 0, 1, 2'd1, 1, 2'd2), {tag, " exec"});
            default:    cyc(1'b0, sv(0, 0, 0, 0, 1, 2'd0, 1, 2'd0), {tag, " exec"});
        endcase
        if (r.cls == K_LD) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, sv(0, 0, 1, 0, 0, 0, 0, 0), {tag, " mem_wait"});
            cyc(1'b1, sv(0, 0, 1, 0, 0, 0, 0, 0), {tag, " mem_ack"});
            cyc(1'b0, sv(0, 0, 0, 0, 1, 0, 1, 2'd1), {tag, " wb"});
        end else if (r.cls == K_ST) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, sv(0, 0, 0, 1, 0, 0, 0, 0), {tag, " mem_wait"});
            cyc(1'b1, sv(0, 0, 0, 1, 1, 0, 0, 0), {tag, " mem_ack"});
        end
        check({tag, " selects"}, {26'd0, IMM_SEL, ALU_SRCA, ALU_SRCB}, {26'd0, r.imm, r.sa, r.sb});
        check_retired({tag, " retired"});
    endtask

    logic [6:0] legal_opcs [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    initial begin
        logic [31:0] rnd;
        #1;
        do_reset("por");

        // LOAD aborted by reset partway through its MEM phase.
        IR = 32'h0000A103;
        cyc(1'b0, sv(0, 1, 0, 0, 0, 0, 0, 0), "abort fetch_wait");
        cyc(1'b1, sv(1, 1, 0, 0, 0, 0, 0, 0), "abort fetch_ack");
        cyc(1'b0, 10'd0, "abort decode");
        cyc(1'b0, 10'd0, "abort exec");
        cyc(1'b0, sv(0, 0, 1, 0, 0, 0, 0, 0), "abort mem_wait");
        do_reset("abort");
        check_retired("abort retired");

        run_instr(32'h00500093, 2, 0, 1'b0, "addi");
        run_instr(32'h0000A103, 0, 3, 1'b0, "lw");
        run_instr(32'h0020A023, 1, 2, 1'b0, "sw");
        run_instr(32'h00000063, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h00000063, 0, 0, 1'b0, "beq_not");
        run_instr(32'h123450B7, 0, 0, 1'b0, "lui");
        run_instr(32'h00001097, 0, 0, 1'b0, "auipc");
        run_instr(32'h008000EF, 0, 0, 1'b0, "jal");
        run_instr(32'h000080E7, 0, 0, 1'b0, "jalr");
        run_instr(32'h002081B3, TO - 1, 0, 1'b0, "add_fetch_edge");
        run_instr(32'h0000A103, 0, TO - 1, 1'b0, "lw_mem_edge");

        // Random mix long enough for RETIRED to wrap.
        for (int n = 0; n < 45; n++) begin
            rnd = $urandom();
            run_instr({rnd[31:7], legal_opcs[$urandom_range(0, 8)]},
                      int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        // Unsupported opcode: trap, silent strobes, ILLEGAL only.
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, "illegal");
        for (int i = 0; i < 20; i++) cyc(1'b1, 10'd0, "illegal trap");
        check("illegal flags", {30'd0, ILLEGAL, BUS_ERR}, 32'd2);
        do_reset("illegal_clr");
        run_instr(32'h00500093, 0, 0, 1'b0, "after_illegal");

        // Fetch never acknowledged: trap exactly TO cycles after FETCH entry.
        do_reset("to");
        for (int i = 0; i < TO; i++) cyc(1'b0, sv(0, 1, 0, 0, 0, 0, 0, 0), "to fetch_wait");
        cyc(1'b1, 10'd0, "to trap");
        for (int i = 0; i < 4; i++) cyc(1'b1, 10'd0, "to trap_hold");
        check("to flags", {30'd0, ILLEGAL, BUS_ERR}, 32'd1);
        check_retired("to retired");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
